shared_register_arbiter: RTL and testbench

Round-robin arbiter that shares one registered output stage (single-entry W-bit register with valid/ready) among N requesters. Sits in front of the registered datapath stage; it selects which requester loads the register each cycle, records the winner's index, and holds the entry until the downstream consumer accepts it. Optional property checks cover the handshake rules, compiled in by macro.

---
 rtl/shared_register_arbiter_pkg.sv | 20 ++
 rtl/shared_register_arbiter_asserts.sv | 30 +++
 rtl/shared_register_arbiter_rr_pick.sv | 29 ++
 rtl/shared_register_arbiter.sv | 101 ++++++++++
 tb/tb_shared_register_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_register_arbiter_pkg.sv
// Shared definitions for the shared_register_arbiter block:
// default sizing, the EMPTY/FULL state type and the pointer-advance helper.
package shared_register_arbiter_pkg;

   localparam int N_DEFAULT = 4;
   localparam int W_DEFAULT = 8;

   // Occupancy of the single output register; out_valid is FULL.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Pointer moves to the requester after the winner, wrapping N-1 -> 0
   // explicitly so non-power-of-two N never lands on an unused index.
   function automatic int next_ptr(input int g, input int n);
      return (g >= n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/shared_register_arbiter_asserts.sv
// Handshake property checker for shared_register_arbiter. Only instantiated
// when HANDSHAKE_ASSERTIONS_EN is defined; silent while ASYNCRESETN is low.
module shared_register_arbiter_asserts #(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int PW = $clog2(N)
) (
   input logic          CLK,
   input logic          ASYNCRESETN,
   input logic [N-1:0]  req_valid,
   input logic [N-1:0]  req_ready,
   input logic          out_valid,
   input logic [W-1:0]  out_data,
   input logic [PW-1:0] out_src,
   input logic          out_ready
);

   a_ready_onehot0 : assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      $onehot0(req_ready));

   a_ready_needs_valid : assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      (req_ready & ~req_valid) == '0);

   a_stall_holds : assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_src) && out_valid));

   a_src_in_range : assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      out_valid |-> (int'(out_src) < N));

endmodule

// File: rtl/shared_register_arbiter_rr_pick.sv
// rr_pick: purely combinational rotating-priority picker. The requester at
// ptr has highest priority, followed by ptr+1, ... wrapping through N-1 to 0.
module rr_pick #(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_valid,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          grant_vld
);

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_vld = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (req_valid[idx]) begin
            grant     = PW'(idx);
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_register_arbiter.sv
// shared_register_arbiter: N requesters share one registered W-bit output
// entry with valid/ready. Round-robin grant, 1-cycle load latency, full
// throughput with simultaneous drain and load.
// Optional handshake checker compiled in with HANDSHAKE_ASSERTIONS_EN.
module shared_register_arbiter
   import shared_register_arbiter_pkg::*;
#(
   parameter  int N  = N_DEFAULT,
   parameter  int W  = W_DEFAULT,
   localparam int PW = $clog2(N)
) (
   input  logic            CLK,
   input  logic            ASYNCRESETN,
   input  logic [N-1:0]    req_valid,
   input  logic [N*W-1:0]  req_data,
   output logic [N-1:0]    req_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic [PW-1:0]   out_src,
   input  logic            out_ready,
   output logic            busy
);

   state_t        state_q, state_d;
   logic [W-1:0]  data_q,  data_d;
   logic [PW-1:0] src_q,   src_d;
   logic [PW-1:0] ptr_q,   ptr_d;
   logic          busy_q,  busy_d;

   logic [PW-1:0] gnt;
   logic          gnt_vld;
   logic          can_load;
   logic          xfer;

   rr_pick #(.N(N)) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .grant     (gnt),
      .grant_vld (gnt_vld)
   );

   // Grant/ready decode and next-state: load on transfer, drain otherwise.
   // Ready is masked by reset so nothing looks accepted while held in reset.
   always_comb begin
      can_load  = (state_q == EMPTY) | out_ready;
      xfer      = gnt_vld & can_load & ASYNCRESETN;
      req_ready = '0;
      if (xfer) req_ready[gnt] = 1'b1;

      state_d = state_q;
      data_d  = data_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      busy_d  = (state_q == FULL) & ~out_ready;
      if (xfer) begin
         state_d = FULL;
         data_d  = req_data[int'(gnt)*W +: W];
         src_d   = gnt;
         ptr_d   = PW'(next_ptr(int'(gnt), N));
      end else if (out_ready) begin
         state_d = EMPTY;
      end
   end

   // Output register, pointer and stall flag; reset discards any held entry.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= EMPTY;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_src   = src_q;
   assign busy      = busy_q;

`ifdef HANDSHAKE_ASSERTIONS_EN
   shared_register_arbiter_asserts #(.N(N), .W(W)) u_asserts (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_src     (out_src),
      .out_ready   (out_ready)
   );
`else
`endif

endmodule

// File: tb/tb_shared_register_arbiter.sv
// Directed bench for shared_register_arbiter: an N=4 and an N=3 instance,
// expected output entries queued when a transfer is driven and popped after
// the loading edge.
module tb_shared_register_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic rst_n;

   logic [3:0]  rv4, rr4;
   logic [31:0] rd4;
   logic        ov4, ordy4, busy4;
   logic [7:0]  od4;
   logic [1:0]  os4;

   logic [2:0]  rv3, rr3;
   logic [23:0] rd3;
   logic        ov3, ordy3, busy3;
   logic [7:0]  od3;
   logic [1:0]  os3;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] s;
   } exp_t;

   exp_t q4[$];
   exp_t q3[$];
   int checks = 0;
   int errors = 0;

   shared_register_arbiter #(.N(4), .W(8)) u_dut4 (
      .CLK(CLK), .ASYNCRESETN(rst_n),
      .req_valid(rv4), .req_data(rd4), .req_ready(rr4),
      .out_valid(ov4), .out_data(od4), .out_src(os4),
      .out_ready(ordy4), .busy(busy4)
   );

   shared_register_arbiter #(.N(3), .W(8)) u_dut3 (
      .CLK(CLK), .ASYNCRESETN(rst_n),
      .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
      .out_valid(ov3), .out_data(od3), .out_src(os3),
      .out_ready(ordy3), .busy(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push4(input logic [7:0] d, input logic [1:0] s);
      exp_t e;
      e.d = d;
      e.s = s;
      q4.push_back(e);
   endtask

   task automatic push3(input logic [7:0] d, input logic [1:0] s);
      exp_t e;
      e.d = d;
      e.s = s;
      q3.push_back(e);
   endtask

   task automatic pop4(input string tag);
      exp_t e;
      if (q4.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected queued entry", tag);
      end else begin
         e = q4.pop_front();
         chk({tag, " valid"}, 32'(ov4), 32'd1);
         chk({tag, " data"},  32'(od4), 32'(e.d));
         chk({tag, " src"},   32'(os4), 32'(e.s));
      end
   endtask

   task automatic pop3(input string tag);
      exp_t e;
      if (q3.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected queued entry", tag);
      end else begin
         e = q3.pop_front();
         chk({tag, " valid"}, 32'(ov3), 32'd1);
         chk({tag, " data"},  32'(od3), 32'(e.d));
         chk({tag, " src"},   32'(os3), 32'(e.s));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rv4   = 4'hF;
      rd4   = 32'h13121110;
      ordy4 = 1'b1;
      rv3   = 3'b000;
      rd3   = 24'h0;
      ordy3 = 1'b1;

      // reset held with every requester valid
      #1;
      chk("rst ready", 32'(rr4), 32'h0);
      chk("rst valid", 32'(ov4), 32'h0);
      chk("rst data",  32'(od4), 32'h0);
      chk("rst src",   32'(os4), 32'h0);
      chk("rst busy",  32'(busy4), 32'h0);
      repeat (2) step();
      chk("rst ready held", 32'(rr4), 32'h0);
      chk("rst valid held", 32'(ov4), 32'h0);
      chk("rst3 valid",     32'(ov3), 32'h0);
      rst_n = 1'b1;

      // round robin over all four, full throughput
      for (int g = 0; g < 5; g++) begin
         #1;
         chk("rr ready", 32'(rr4), 32'(4'b0001 << (g % 4)));
         push4(8'(8'h10 + (g % 4)), 2'(g % 4));
         step();
         pop4("rr");
      end

      // load 0xA5 from requester 2 (ptr is 1 here)
      rv4 = 4'b0100;
      rd4[23:16] = 8'hA5;
      #1;
      chk("stall load ready", 32'(rr4), 32'h4);
      push4(8'hA5, 2'd2);
      step();
      pop4("stall load");

      // three stalled cycles
      ordy4 = 1'b0;
      rv4   = 4'b1011;
      rd4[31:24] = 8'h33;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("stall ready", 32'(rr4), 32'h0);
         step();
         chk("stall data",  32'(od4), 32'hA5);
         chk("stall src",   32'(os4), 32'h2);
         chk("stall valid", 32'(ov4), 32'h1);
         chk("stall busy",  32'(busy4), 32'h1);
      end

      // release: ptr=3 so requester 3 wins over 0 and 1
      ordy4 = 1'b1;
      #1;
      chk("unstall ready", 32'(rr4), 32'h8);
      push4(8'h33, 2'd3);
      step();
      pop4("unstall");
      chk("unstall busy", 32'(busy4), 32'h0);

      // simultaneous drain and load, no bubble
      rv4 = 4'b0010;
      rd4[15:8] = 8'h5C;
      #1;
      chk("dl ready", 32'(rr4), 32'h2);
      push4(8'h5C, 2'd1);
      step();
      pop4("drain+load");

      // pure drain keeps data and src
      rv4 = 4'b0000;
      step();
      chk("drain valid", 32'(ov4), 32'h0);
      chk("drain data",  32'(od4), 32'h5C);
      chk("drain src",   32'(os4), 32'h1);
      chk("drain busy",  32'(busy4), 32'h0);

      // reset in the middle of a stall
      rv4 = 4'b0001;
      rd4[7:0] = 8'h77;
      #1;
      chk("mid ready", 32'(rr4), 32'h1);
      push4(8'h77, 2'd0);
      step();
      pop4("mid load");
      ordy4 = 1'b0;
      rv4   = 4'b0000;
      step();
      chk("mid busy", 32'(busy4), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst valid", 32'(ov4), 32'h0);
      chk("async rst data",  32'(od4), 32'h0);
      chk("async rst src",   32'(os4), 32'h0);
      chk("async rst busy",  32'(busy4), 32'h0);
      chk("async rst ready", 32'(rr4), 32'h0);
      #1;
      rst_n = 1'b1;
      ordy4 = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         chk("post rst valid", 32'(ov4), 32'h0);
      end
      rv4 = 4'hF;
      #1;
      chk("post rst ptr", 32'(rr4), 32'h1);
      rv4 = 4'h0;

      // N=3: wrap from requester 2 back to 0
      rv3 = 3'b100;
      rd3[23:16] = 8'h3C;
      #1;
      chk("n3 ready2", 32'(rr3), 32'h4);
      push3(8'h3C, 2'd2);
      step();
      pop3("n3 last");
      rv3 = 3'b111;
      rd3 = 24'h323130;
      #1;
      chk("n3 wrap ready", 32'(rr3), 32'h1);
      push3(8'h30, 2'd0);
      step();
      pop3("n3 wrap");
      #1;
      chk("n3 next ready", 32'(rr3), 32'h2);
      push3(8'h31, 2'd1);
      step();
      pop3("n3 next");
      rv3 = 3'b000;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
